// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester-side and APB-side signal bundle for apb_master_arbiter
interface apb_master_arbiter_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic [1:0]                  req_i;
  logic [1:0]                  we_i;
  logic [2*APB_ADDR_WIDTH-1:0] addr_i;
  logic [2*APB_DATA_WIDTH-1:0] wdata_i;
  logic [1:0]                  gnt_o;
  logic [1:0]                  rvalid_o;
  logic [APB_DATA_WIDTH-1:0]   rdata_o;
  logic                        err_o;
  logic [APB_ADDR_WIDTH-1:0]   paddr_o;
  logic [APB_DATA_WIDTH-1:0]   pwdata_o;
  logic                        pwrite_o;
  logic                        psel_o;
  logic                        penable_o;
  logic                        pready_i;
  logic [APB_DATA_WIDTH-1:0]   prdata_i;
  logic                        pslverr_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, pready_i, prdata_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, pready_i, prdata_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin arbiter driving one APB master port
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                  clk_i,
  input logic                  rst_i,
  apb_master_arbiter_if.master bus
);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_master_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          last_q;
  logic          owner_q;
  logic          win;
  logic          take;
  logic          complete;
  logic          expired;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          pwrite_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      cnt_q <= '0;
    end else if (state_q == S_ACCESS && !bus.pready_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A ready in the final allowed cycle still wins because complete is checked first.
  assign expired = (state_q == S_ACCESS) && !bus.pready_i &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win      = 1'b0;
    take     = 1'b0;
    complete = 1'b0;
    case (bus.req_i)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
    case (state_q)
      S_IDLE: begin
        if (|bus.req_i && !rst_i) begin
          take    = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.pready_i) begin
          complete = 1'b1;
          state_d  = S_RESP;
        end else if (expired) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (take) begin
        paddr_q  <= win ? bus.addr_i[2*AW-1:AW] : bus.addr_i[AW-1:0];
        pwdata_q <= win ? bus.wdata_i[2*DW-1:DW] : bus.wdata_i[DW-1:0];
        pwrite_q <= win ? bus.we_i[1] : bus.we_i[0];
        owner_q  <= win;
        last_q   <= win;
      end
      if (complete) begin
        rdata_q <= pwrite_q ? '0 : bus.prdata_i;
        err_q   <= bus.pslverr_i;
      end else if (expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus.gnt_o     = take ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rvalid_o  = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rdata_o   = rdata_q;
  assign bus.err_o     = err_q;
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.psel_o    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign bus.penable_o = (state_q == S_ACCESS);
endmodule
